// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and byte-enable helper for the MEM-stage data responder
package mem_pkg;

    typedef enum logic [1:0] {
        MASK_BYTE = 2'b00,
        MASK_HALF = 2'b01,
        MASK_WORD = 2'b10
    } mask_type_e;

    typedef enum logic {
        EXT_SIGN = 1'b0,
        EXT_ZERO = 1'b1
    } ext_type_e;

    typedef enum logic {
        IDLE = 1'b0,
        RSP  = 1'b1
    } rsp_state_e;

    // The reserved encoding 2'b11 behaves as a full word.
    function automatic mask_type_e to_mask(input logic [1:0] raw);
        case (raw)
            2'b00:   to_mask = MASK_BYTE;
            2'b01:   to_mask = MASK_HALF;
            default: to_mask = MASK_WORD;
        endcase
    endfunction

    function automatic logic [3:0] be_gen(input mask_type_e mask, input logic [1:0] addr_lo);
        case (mask)
            MASK_BYTE: be_gen = 4'b0001 << addr_lo;
            MASK_HALF: be_gen = 4'b0011 << {addr_lo[1], 1'b0};
            default:   be_gen = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - lane extraction and sign/zero extension of a RAM word for loads
module load_extract
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  mask_type_e  mask,
    input  ext_type_e   ext,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[8*addr_lo +: 8];
        half_lane = word[16*addr_lo[1] +: 16];
        case (mask)
            MASK_BYTE: result = (ext == EXT_ZERO) ? {24'b0, byte_lane}
                                                  : {{24{byte_lane[7]}}, byte_lane};
            MASK_HALF: result = (ext == EXT_ZERO) ? {16'b0, half_lane}
                                                  : {{16{half_lane[15]}}, half_lane};
            default:   result = word;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - MEM-stage load/store responder over an inferred word RAM
// Optional misaligned-access trapping is enabled by defining MISALIGN_TRAP_EN.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    input  logic [1:0]        i_mask_type,
    input  logic              i_ext_type,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_misaligned
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem [DEPTH_WORDS];
    rsp_state_e       state;
    mask_type_e       req_mask;
    logic [IDX_W-1:0] idx;
    logic [1:0]       addr_lo;
    logic             accept;
    logic             mis;
    logic             wr_en;
    logic             rd_en;
    logic             rsp_start;
    logic [3:0]       be;
    logic [31:0]      wdata_lane;

    logic [31:0]      rd_word;
    logic [1:0]       lat_lo;
    mask_type_e       lat_mask;
    ext_type_e        lat_ext;
    logic             rsp_mis;
    logic [31:0]      ext_word;

    assign req_mask    = to_mask(i_mask_type);
    assign idx         = i_req_addr[IDX_W+1:2];
    assign addr_lo     = i_req_addr[1:0];
    assign o_req_ready = (state == IDLE) | ((state == RSP) & i_rsp_ready);
    assign accept      = i_req_valid & o_req_ready;

`ifdef MISALIGN_TRAP_EN
    assign mis = ((req_mask == MASK_HALF) & addr_lo[0]) |
                 ((req_mask == MASK_WORD) & (addr_lo != 2'b00));
`else
    assign mis = 1'b0;
`endif

    // Misaligned requests of either kind become error responses instead of RAM accesses.
    assign rsp_start = accept & (~i_req_we | mis);
    assign wr_en     = accept & i_req_we & ~mis & ~i_rst;
    assign rd_en     = accept & ~i_req_we & ~mis & ~i_rst;
    assign be        = be_gen(req_mask, addr_lo);

    always_comb begin
        case (req_mask)
            MASK_BYTE: wdata_lane = {4{i_req_wdata[7:0]}};
            MASK_HALF: wdata_lane = {2{i_req_wdata[15:0]}};
            default:   wdata_lane = i_req_wdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && be[b]) begin
                mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
            end
        end
        if (rd_en) begin
            rd_word <= mem[idx];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            o_rsp_valid <= 1'b0;
            rsp_mis     <= 1'b0;
            lat_lo      <= 2'b00;
            lat_mask    <= MASK_WORD;
            lat_ext     <= EXT_SIGN;
        end else if (rsp_start) begin
            state       <= RSP;
            o_rsp_valid <= 1'b1;
            rsp_mis     <= mis;
            lat_lo      <= addr_lo;
            lat_mask    <= req_mask;
            lat_ext     <= ext_type_e'(i_ext_type);
        end else if ((state == RSP) && i_rsp_ready) begin
            state       <= IDLE;
            o_rsp_valid <= 1'b0;
            rsp_mis     <= 1'b0;
        end
    end

    load_extract u_load_extract (
        .word    (rd_word),
        .addr_lo (lat_lo),
        .mask    (lat_mask),
        .ext     (lat_ext),
        .result  (ext_word)
    );

    assign o_rsp_rdata = (o_rsp_valid && !rsp_mis) ? ext_word : 32'h0;

`ifdef MISALIGN_TRAP_EN
    assign o_misaligned = o_rsp_valid & rsp_mis;
`else
    assign o_misaligned = 1'b0;
`endif

    generate
        if (ADDR_W > IDX_W + 2) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^i_req_addr[ADDR_W-1:IDX_W+2];
        end
    endgenerate

endmodule
